// File: rtl/core_sequencer_pkg.sv
// Shared definitions for the 8-bit core sequencer: opcode/funct encodings,
// FSM state encoding and instruction field extraction.
package core_sequencer_pkg;

   typedef enum logic {
      OP_R = 1'b0,
      OP_B = 1'b1
   } op_e;

   typedef enum logic [1:0] {
      F_ADD = 2'd0,
      F_AND = 2'd1,
      F_OR  = 2'd2,
      F_XOR = 2'd3
   } r_funct_e;

   typedef enum logic {
      B_BEQ = 1'b0,
      B_BLT = 1'b1
   } b_funct_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_EXEC   = 2'd2,
      ST_COMMIT = 2'd3
   } state_e;

   // Instruction layout: rs1[7:6] rd[5:4] funct[3:2] b_funct[1] op[0], imm[7:2]
   function automatic op_e f_op(input logic [7:0] ir);
      return op_e'(ir[0]);
   endfunction

   function automatic b_funct_e f_b_funct(input logic [7:0] ir);
      return b_funct_e'(ir[1]);
   endfunction

   function automatic r_funct_e f_funct(input logic [7:0] ir);
      return r_funct_e'(ir[3:2]);
   endfunction

   function automatic logic [1:0] f_rd(input logic [7:0] ir);
      return ir[5:4];
   endfunction

   function automatic logic [1:0] f_rs1(input logic [7:0] ir);
      return ir[7:6];
   endfunction

   function automatic logic [5:0] f_imm(input logic [7:0] ir);
      return ir[7:2];
   endfunction

endpackage

// File: rtl/core_regfile.sv
// 4-entry register file: two async operand read ports, one async debug read
// port and a single synchronous write port shared by the core and debug.
module core_regfile #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_core_we,
   input  logic [1:0]    i_core_sel,
   input  logic [DW-1:0] i_core_wdata,
   input  logic          i_dbg_we,
   input  logic [1:0]    i_dbg_sel,
   input  logic [DW-1:0] i_dbg_wdata,
   input  logic [1:0]    i_rs1_sel,
   input  logic [1:0]    i_rd_sel,
   output logic [DW-1:0] o_rs1_data,
   output logic [DW-1:0] o_rd_data,
   output logic [DW-1:0] o_dbg_rdata
);

   logic [DW-1:0] r_regs [4];
   logic          w_we;
   logic [1:0]    w_sel;
   logic [DW-1:0] w_wdata;

   // The sequencer never enables both sources in the same cycle; core wins anyway.
   assign w_we    = i_core_we | i_dbg_we;
   assign w_sel   = i_core_we ? i_core_sel   : i_dbg_sel;
   assign w_wdata = i_core_we ? i_core_wdata : i_dbg_wdata;

   // NOTE: this storage is reset because the architecture defines all registers
   // as zero after reset; a large RAM would normally be left unreset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) r_regs[i] <= '0;
      end else if (w_we) begin
         // NOTE: state updates use <= so every register samples pre-edge values.
         r_regs[w_sel] <= w_wdata;
      end
   end

   assign o_rs1_data  = r_regs[i_rs1_sel];
   assign o_rd_data   = r_regs[i_rd_sel];
   assign o_dbg_rdata = r_regs[i_dbg_sel];

endmodule

// File: rtl/core_sequencer.sv
// Fetch/execute controller for the 8-bit core: fetches into IR, drives the
// external ALU, and commits either a register writeback or a PC offset.
module core_sequencer
   import core_sequencer_pkg::*;
#(
   parameter int DW = 8,
   parameter int IW = 8,
   parameter int PW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          run_en,
   output logic          imem_req,
   output logic [PW-1:0] imem_addr,
   input  logic          imem_ack,
   input  logic [IW-1:0] imem_data,
   output logic [IW-1:0] alu_instruction,
   output logic [DW-1:0] alu_rs1_data,
   output logic [DW-1:0] alu_rd_data,
   input  logic [DW-1:0] alu_out,
   output logic [PW-1:0] pc,
   output logic          retire,
   output logic          busy,
   input  logic          dbg_we,
   input  logic [1:0]    dbg_sel,
   input  logic [DW-1:0] dbg_wdata,
   output logic [DW-1:0] dbg_rdata
);

   state_e        r_state;
   state_e        w_next_state;
   logic [PW-1:0] r_pc;
   logic [IW-1:0] r_ir;
   logic [DW-1:0] r_result;
   logic          w_core_we;
   logic          w_dbg_we;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next_state;
   end

   // NOTE: default assignment first so no path through the case infers a latch.
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         ST_IDLE:   if (run_en) w_next_state = ST_FETCH;
         ST_FETCH:  if (imem_ack) w_next_state = ST_EXEC;
         ST_EXEC:   w_next_state = ST_COMMIT;
         ST_COMMIT: w_next_state = run_en ? ST_FETCH : ST_IDLE;
         default:   w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      imem_req  = (r_state == ST_FETCH);
      retire    = (r_state == ST_COMMIT);
      busy      = (r_state != ST_IDLE);
      w_core_we = (r_state == ST_COMMIT) && (f_op(r_ir) == OP_R);
      w_dbg_we  = (r_state == ST_IDLE) && dbg_we;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc     <= '0;
         r_ir     <= '0;
         r_result <= '0;
      end else begin
         if (r_state == ST_FETCH && imem_ack) r_ir <= imem_data;
         if (r_state == ST_EXEC) r_result <= alu_out;
         if (r_state == ST_COMMIT) begin
            // Branch offsets are unsigned and wrap modulo 2^PW.
            if (f_op(r_ir) == OP_R) r_pc <= r_pc + PW'(1);
            else                    r_pc <= r_pc + PW'(r_result);
         end
      end
   end

   core_regfile #(.DW(DW)) u_regfile (
      .clk          (clk),
      .rst          (rst),
      .i_core_we    (w_core_we),
      .i_core_sel   (f_rd(r_ir)),
      .i_core_wdata (r_result),
      .i_dbg_we     (w_dbg_we),
      .i_dbg_sel    (dbg_sel),
      .i_dbg_wdata  (dbg_wdata),
      .i_rs1_sel    (f_rs1(r_ir)),
      .i_rd_sel     (f_rd(r_ir)),
      .o_rs1_data   (alu_rs1_data),
      .o_rd_data    (alu_rd_data),
      .o_dbg_rdata  (dbg_rdata)
   );

   assign imem_addr       = r_pc;
   assign pc              = r_pc;
   assign alu_instruction = r_ir;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: stimulus pushes expected commits into a
// scoreboard that a separate monitor checks on every retire pulse.
module tb_core_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       run_en;
   logic       imem_req;
   logic [7:0] imem_addr;
   logic       imem_ack;
   logic [7:0] imem_data;
   logic [7:0] alu_instruction;
   logic [7:0] alu_rs1_data;
   logic [7:0] alu_rd_data;
   logic [7:0] alu_out;
   logic [7:0] pc;
   logic       retire;
   logic       busy;
   logic       dbg_we;
   logic [1:0] dbg_sel;
   logic [7:0] dbg_wdata;
   logic [7:0] dbg_rdata;

   int total = 0;
   int bad   = 0;
   int n_pushed  = 0;
   int n_retired = 0;

   typedef struct {
      logic [7:0] instr;
      logic [7:0] pc_now;
      logic [7:0] pc_next;
   } exp_t;

   exp_t sb[$];

   core_sequencer #(.DW(8), .IW(8), .PW(8)) dut (
      .clk             (clk),
      .rst             (rst),
      .run_en          (run_en),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ack        (imem_ack),
      .imem_data       (imem_data),
      .alu_instruction (alu_instruction),
      .alu_rs1_data    (alu_rs1_data),
      .alu_rd_data     (alu_rd_data),
      .alu_out         (alu_out),
      .pc              (pc),
      .retire          (retire),
      .busy            (busy),
      .dbg_we          (dbg_we),
      .dbg_sel         (dbg_sel),
      .dbg_wdata       (dbg_wdata),
      .dbg_rdata       (dbg_rdata)
   );

   always #5 clk = ~clk;

   // External ALU model.
   function automatic logic [7:0] alu_model(input logic [7:0] ins, input logic [7:0] a,
                                            input logic [7:0] b);
      logic [7:0] imm;
      imm = {2'b00, ins[7:2]};
      if (ins[0] == 1'b0) begin
         case (ins[3:2])
            2'd0:    return a + b;
            2'd1:    return a & b;
            2'd2:    return a | b;
            default: return a ^ b;
         endcase
      end
      if (ins[1] == 1'b0) return (a == b) ? imm : 8'd1;
      return (a < b) ? imm : 8'd1;
   endfunction

   always_comb alu_out = alu_model(alu_instruction, alu_rs1_data, alu_rd_data);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every retire must match the oldest expected commit.
   initial begin
      forever begin
         @(negedge clk);
         if (retire === 1'b1) begin
            exp_t e;
            n_retired++;
            if (sb.size() == 0) begin
               check("unexpected_retire", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("commit_instr", alu_instruction, e.instr);
               check("commit_pc", pc, e.pc_now);
               @(negedge clk);
               check("pc_after_commit", pc, e.pc_next);
               check("retire_pulse_width", retire, 1'b0);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic dbg_write(input logic [1:0] sel, input logic [7:0] data);
      dbg_we = 1'b1; dbg_sel = sel; dbg_wdata = data;
      @(negedge clk);
      dbg_we = 1'b0;
   endtask

   task automatic dbg_check(input string name, input logic [1:0] sel, input logic [7:0] exp);
      dbg_sel = sel;
      #1;
      check(name, dbg_rdata, exp);
   endtask

   // Issue one instruction; caller is at a negedge with the FSM in IDLE or FETCH.
   task automatic exec_one(input logic [7:0] instr, input int delay, input logic [7:0] pc_exp,
                           input logic [7:0] pc_nxt, input bit keep_run, input bit stray,
                           input bit drop_in_exec);
      int n;
      exp_t e;
      run_en = 1'b1;
      n = 0;
      while (imem_req !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (imem_req !== 1'b1) begin
         check("fetch_req_timeout", imem_req, 1'b1);
         return;
      end
      check("fetch_addr", imem_addr, pc_exp);
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         if (stray && i == 1) begin
            dbg_we = 1'b1; dbg_sel = 2'd0; dbg_wdata = 8'hAA;
         end
         check("wait_req_held", imem_req, 1'b1);
         check("wait_addr_held", imem_addr, pc_exp);
      end
      imem_ack = 1'b1;
      imem_data = instr;
      e.instr = instr; e.pc_now = pc_exp; e.pc_next = pc_nxt;
      sb.push_back(e);
      n_pushed++;
      @(negedge clk);
      imem_ack = stray;
      imem_data = stray ? 8'hFF : 8'h00;
      check("exec_ir", alu_instruction, instr);
      check("exec_busy", busy, 1'b1);
      if (drop_in_exec) run_en = 1'b0;
      @(negedge clk);
      imem_ack = 1'b0;
      dbg_we = 1'b0;
      check("retire_latency", retire, 1'b1);
      if (!keep_run) run_en = 1'b0;
   endtask

   initial begin
      rst = 1'b1; run_en = 1'b0; imem_ack = 1'b0; imem_data = 8'h00;
      dbg_we = 1'b0; dbg_sel = 2'd0; dbg_wdata = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_pc", pc, 8'h00);
      check("rst_req", imem_req, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_retire", retire, 1'b0);
      for (int i = 0; i < 4; i++) dbg_check("rst_reg", 2'(i), 8'h00);

      // ADD r2 = r1 + r2 with immediate ack
      @(negedge clk);
      dbg_write(2'd1, 8'h05);
      dbg_write(2'd2, 8'h03);
      dbg_check("dbg_r1", 2'd1, 8'h05);
      dbg_check("dbg_r2", 2'd2, 8'h03);
      exec_one(8'h60, 0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("idle_after_add", busy, 1'b0);
      dbg_check("add_r2", 2'd2, 8'h08);

      // Walk pc to 0x10 with back-to-back taken BEQ r0,r0 imm=3
      for (int i = 0; i < 5; i++)
         exec_one(8'h0D, 0, 8'(1 + 3 * i), 8'(4 + 3 * i), i != 4, 1'b0, 1'b0);
      @(negedge clk);
      dbg_write(2'd0, 8'h07);
      exec_one(8'h0D, 0, 8'h10, 8'h13, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      dbg_check("beq_r0", 2'd0, 8'h07);
      dbg_check("beq_r1", 2'd1, 8'h05);
      dbg_check("beq_r2", 2'd2, 8'h08);
      dbg_check("beq_r3", 2'd3, 8'h00);

      // BLT not taken, then walk to 0xFF and wrap with a not-taken branch
      exec_one(8'h0F, 0, 8'h13, 8'h14, 1'b1, 1'b0, 1'b0);
      exec_one(8'hFD, 0, 8'h14, 8'h53, 1'b1, 1'b0, 1'b0);
      exec_one(8'hFD, 0, 8'h53, 8'h92, 1'b1, 1'b0, 1'b0);
      exec_one(8'hFD, 0, 8'h92, 8'hD1, 1'b1, 1'b0, 1'b0);
      exec_one(8'hAD, 0, 8'hD1, 8'hFC, 1'b1, 1'b0, 1'b0);
      exec_one(8'h0D, 0, 8'hFC, 8'hFF, 1'b1, 1'b0, 1'b0);
      exec_one(8'h0F, 0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("wrap_pc", pc, 8'h00);

      // XOR r3 = r1 ^ r3 with 4-cycle ack delay, stray ack and debug write while busy
      exec_one(8'h7C, 4, 8'h00, 8'h01, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      dbg_check("busy_dbg_r0", 2'd0, 8'h07);
      dbg_check("xor_r3", 2'd3, 8'h05);

      // OR r1 = r0 | r1 with run_en dropped in EXEC
      exec_one(8'h18, 0, 8'h01, 8'h02, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      check("drop_idle_busy", busy, 1'b0);
      repeat (3) begin
         @(negedge clk);
         check("drop_no_fetch", imem_req, 1'b0);
      end
      dbg_check("or_r1", 2'd1, 8'h07);
      check("retire_count", n_retired, n_pushed);
      check("sb_empty", sb.size(), 0);

      // Reset in the middle of FETCH
      run_en = 1'b1;
      @(negedge clk);
      check("pre_rst_req", imem_req, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_req", imem_req, 1'b0);
      check("midrst_pc", pc, 8'h00);
      check("midrst_busy", busy, 1'b0);
      run_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) dbg_check("midrst_reg", 2'(i), 8'h00);
      repeat (2) @(negedge clk);
      check("final_retire_count", n_retired, n_pushed);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Multi-cycle fetch/execute controller for the 8-bit core. It is the consumer side of the ALU interface.
- Fetches one instruction word from instruction memory over a req/ack handshake and holds it in an instruction register (IR).
- Drives the ALU with the instruction and two register operands, then commits the ALU result: register writeback for R-type, PC offset for B-type.
- Owns the PC and a 4-entry register file, with a debug access port for bring-up and verification.

Parameters:
- DW, 8, data/register width
- IW, 8, instruction width
- PW, 8, program counter width

Ports:
- clk  in  1  single core clock
- rst  in  1  asynchronous, active-high reset
- run_en  in  1  allows leaving IDLE and starting the next instruction
- imem_req  out  1  fetch request
- imem_addr  out  PW  fetch address, equal to pc
- imem_ack  in  1  fetch data valid this cycle
- imem_data  in  IW  instruction word
- alu_instruction  out  IW  IR contents
- alu_rs1_data  out  DW  reg[IR[7:6]]
- alu_rd_data  out  DW  reg[IR[5:4]]
- alu_out  in  DW  ALU result, combinational from the above
- pc  out  PW  current PC
- retire  out  1  one-cycle pulse per committed instruction
- busy  out  1  high in any state other than IDLE
- dbg_we  in  1  debug register write
- dbg_sel  in  2  debug register index
- dbg_wdata  in  DW  debug write data
- dbg_rdata  out  DW  reg[dbg_sel], combinational

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values:
  - pc=0, IR=0, all registers 0.
  - imem_req=0, retire=0, busy=0.
  - State IDLE.
  - rst asserted mid-operation aborts immediately; no partial commit.
- FSM states: IDLE, FETCH, EXEC, COMMIT.
- IDLE:
  - If run_en=1, go to FETCH next cycle.
  - dbg_we writes reg[dbg_sel]=dbg_wdata only in IDLE; ignored in all other states.
- FETCH:
  - imem_req=1, imem_addr=pc; both held stable until imem_ack.
  - On the ack cycle: IR<=imem_data, go to EXEC.
  - imem_ack outside FETCH is ignored.
- EXEC:
  - alu_* driven from IR and the register file.
  - Result register <= alu_out; go to COMMIT.
- COMMIT:
  - retire=1 for this cycle.
  - Register operand fields always decode from IR[7:6] and IR[5:4], including for B-type.
  - IR[0]==OP_R: reg[IR[5:4]] <= result; pc <= pc+1.
  - IR[0]==OP_B: pc <= pc + result, zero-extended/truncated to PW, modulo 2^PW. Not-taken yields result=1 (pc+1); taken yields pc+imm.
  - Next state: FETCH if run_en=1, else IDLE.
- run_en deasserted mid-instruction: the current instruction completes and commits, then the FSM goes to IDLE.
- Minimum latency with zero-wait ack: 3 cycles per instruction (FETCH, EXEC, COMMIT). retire falls on the 3rd cycle after imem_req rises.
- PC wraps: 0xFF+1 -> 0x00.
- Taken branch with imm=0 leaves pc unchanged (self-loop). This is legal.
- Only one register write per commit; no hazards, because execution is strictly sequential.

Decomposition:
- Shared package/definitions: OP_R=0, OP_B=1.
- R funct: ADD=0, AND=1, OR=2, XOR=3. B funct: BEQ=0, BLT=1.
- Field slice positions: op[0], b_funct[1], funct[3:2], rd[5:4], rs1[7:6], imm[7:2].
- FSM state encodings also go in the package.
- One natural sub-module: core_regfile (4xDW, two async read ports, one debug read port, one synchronous write port with muxed core/debug source).

Test Plan:
- Reset, then hold idle -> pc=0x00, imem_req=0, busy=0, dbg_rdata=0 for every dbg_sel.
- dbg write r1=0x05, r2=0x03; run_en=1; imem_data=0x60 (ADD rs1=r1, rd=r2) with immediate ack -> retire 3 cycles after req rises; r2=0x08; pc=0x01.
- pc=0x10; r0=0x07; instr 0x0D (BEQ r0,r0, imm=3) -> pc=0x13, no register changes.
- Instr 0x0F (BLT r0,r0, imm=3) -> not taken, pc+1. Separately, pc=0xFF with not-taken branch -> pc=0x00.
- Ack delayed 4 cycles -> imem_req and imem_addr held stable throughout; stray ack in EXEC ignored; dbg_we during busy leaves registers unchanged.
- run_en dropped during EXEC -> instruction commits, retire pulses once, FSM returns to IDLE. rst asserted mid-FETCH -> imem_req=0 immediately, pc=0.
